dm_arbiter: RTL

Two-requester arbiter for the single-port data memory (256 x 8, dm1 geometry). It shares the memory port between the core load/store path (requester 0) and a debug/loader port (requester 1). The debug port is used to preload and inspect data memory without hierarchical pokes. It sits between the core and the memory instance inside top_level, and issues at most one memory access per cycle with a one-cycle read return.

---
 rtl/dm_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-requester arbiter sharing the single-port data memory between the core
// load/store path (R0) and the debug/loader port (R1), with lock and hand-off.
module dm_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned MAXLOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAXLOCK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;      // 0: R0 granted most recently, 1: R1
  logic [CW-1:0] lockcnt_q, lockcnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rhold0_q, rhold0_d;
  logic [DW-1:0] rhold1_q, rhold1_d;
  logic          sel0, sel1;
  logic [CW-1:0] cnt_inc;

  // Grant selection: owner first (unless its lock budget is spent), then round-robin
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (owner_q == OWN_R0 && req0) begin
      if (lockcnt_q == LOCK_MAX && req1) sel1 = 1'b1;
      else                               sel0 = 1'b1;
    end else if (owner_q == OWN_R1 && req1) begin
      if (lockcnt_q == LOCK_MAX && req0) sel0 = 1'b1;
      else                               sel1 = 1'b1;
    end else if (req0 && req1) begin
      if (last_q) sel0 = 1'b1;
      else        sel1 = 1'b1;
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  assign cnt_inc = (lockcnt_q == LOCK_MAX) ? lockcnt_q : lockcnt_q + CW'(1);

  always_comb begin
    owner_d   = OWN_NONE;
    lockcnt_d = '0;
    last_d    = last_q;
    if (sel0) begin
      last_d = 1'b0;
      if (lock0) begin
        owner_d   = OWN_R0;
        lockcnt_d = (owner_q == OWN_R0) ? cnt_inc : CW'(1);
      end
    end else if (sel1) begin
      last_d = 1'b1;
      if (lock1) begin
        owner_d   = OWN_R1;
        lockcnt_d = (owner_q == OWN_R1) ? cnt_inc : CW'(1);
      end
    end
  end

  // Memory port mux; idle port drives zeros
  always_comb begin
    mem_en    = sel0 | sel1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (sel1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read data passes through in the return cycle and is held afterwards
  always_comb begin
    rvalid0_d = sel0 & ~we0;
    rvalid1_d = sel1 & ~we1;
    rdata0    = rvalid0_q ? mem_rdata : rhold0_q;
    rdata1    = rvalid1_q ? mem_rdata : rhold1_q;
    rhold0_d  = rdata0;
    rhold1_d  = rdata1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NONE;
      last_q    <= 1'b1;
      lockcnt_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rhold0_q  <= '0;
      rhold1_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      lockcnt_q <= lockcnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rhold0_q  <= rhold0_d;
      rhold1_q  <= rhold1_d;
    end
  end

  assign gnt0    = sel0;
  assign gnt1    = sel1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign busy    = (owner_q != OWN_NONE);

endmodule
